// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: turns scan coordinates into frame-buffer write requests.
// Stage A computes the linear address and issues the replay-memory read.
// Stage B merges the returned pixel (or black) and pushes into a small FIFO
// whose head drives the valid/ready frame-buffer port.
// Optional build macro: FB_PIXEL_WRITER_TESTPAT_EN (checkerboard instead of black).
module fb_pixel_writer #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [9:0]       x,
  input  logic [8:0]       y,
  input  logic             draw_black,
  output logic [18:0]      src_raddr,
  input  logic [PIX_W-1:0] src_rdata,
  output logic             fb_we,
  input  logic             fb_ready,
  output logic [18:0]      fb_addr,
  output logic [PIX_W-1:0] fb_wdata,
  output logic             overflow,
  output logic             frame_done
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [9:0]  HResX    = 10'(H_RES);
  localparam logic [8:0]  VResY    = 9'(V_RES);
  localparam logic [18:0] LastAddr = 19'(H_RES * V_RES - 1);
  localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

  logic [18:0] lin_addr;
  logic        in_ok;

  // 640 = 512 + 128, so the default geometry needs only shifts and adds.
  if (H_RES == 640) begin : g_shift_addr
    assign lin_addr = ({10'd0, y} << 9) + ({10'd0, y} << 7) + {9'd0, x};
  end else begin : g_mul_addr
    assign lin_addr = ({10'd0, y} * 19'(H_RES)) + {9'd0, x};
  end

  assign in_ok = in_valid && (x < HResX) && (y < VResY);

  // Pipeline stage registers
  logic        a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [18:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic        a_black_q, a_black_d, b_black_q, b_black_d;
`ifdef FB_PIXEL_WRITER_TESTPAT_EN
  logic        a_chk_q, a_chk_d, b_chk_q, b_chk_d;
`endif

  // FIFO state
  logic [18:0]      mem_addr_q [FIFO_DEPTH];
  logic [18:0]      mem_addr_d [FIFO_DEPTH];
  logic [PIX_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [PIX_W-1:0] mem_data_d [FIFO_DEPTH];
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d;

  logic             fifo_full, fifo_empty, pop, push_ok;
  logic [PIX_W-1:0] b_pixel;

  // Stage A captures accepted coordinates; address holds while idle.
  always_comb begin
    a_valid_d = in_ok;
    a_addr_d  = in_ok ? lin_addr : a_addr_q;
    a_black_d = in_ok ? draw_black : a_black_q;
    b_valid_d = a_valid_q;
    b_addr_d  = a_addr_q;
    b_black_d = a_black_q;
`ifdef FB_PIXEL_WRITER_TESTPAT_EN
    a_chk_d   = in_ok ? (x[4] ^ y[4]) : a_chk_q;
    b_chk_d   = a_chk_q;
`endif
  end

  // Stage B pixel select: replay data arrives this cycle for the stage-B address.
  always_comb begin
    b_pixel = src_rdata;
    if (b_black_q) begin
`ifdef FB_PIXEL_WRITER_TESTPAT_EN
      b_pixel = b_chk_q ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
      b_pixel = {PIX_W{1'b0}};
`endif
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop        = !fifo_empty && fb_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = b_valid_q && (!fifo_full || pop);

  // FIFO pointer/storage update, sticky overflow and frame-end detection.
  always_comb begin
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (push_ok) begin
      mem_addr_d[wr_ptr_q[PtrW-1:0]] = b_addr_q;
      mem_data_d[wr_ptr_q[PtrW-1:0]] = b_pixel;
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    overflow_d   = overflow_q | (b_valid_q && fifo_full && !pop);
    frame_done_d = pop && (fb_addr == LastAddr);
  end

  // All state, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q    <= 1'b0;
      a_addr_q     <= '0;
      a_black_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      b_addr_q     <= '0;
      b_black_q    <= 1'b0;
`ifdef FB_PIXEL_WRITER_TESTPAT_EN
      a_chk_q      <= 1'b0;
      b_chk_q      <= 1'b0;
`endif
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      a_valid_q    <= a_valid_d;
      a_addr_q     <= a_addr_d;
      a_black_q    <= a_black_d;
      b_valid_q    <= b_valid_d;
      b_addr_q     <= b_addr_d;
      b_black_q    <= b_black_d;
`ifdef FB_PIXEL_WRITER_TESTPAT_EN
      a_chk_q      <= a_chk_d;
      b_chk_q      <= b_chk_d;
`endif
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign src_raddr  = a_addr_q;
  assign fb_we      = !fifo_empty;
  assign fb_addr    = mem_addr_q[rd_ptr_q[PtrW-1:0]];
  assign fb_wdata   = mem_data_q[rd_ptr_q[PtrW-1:0]];
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Testbench for fb_pixel_writer: directed table of per-cycle vectors plus
// hand-written stall, full-FIFO and reset sequences. Replay memory is a
// one-cycle-latency model returning addr[7:0] ^ 8'hA0.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        draw_black;
  logic [18:0] src_raddr;
  logic [7:0]  src_rdata;
  logic        fb_we;
  logic        fb_ready;
  logic [18:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        overflow;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

`ifdef FB_PIXEL_WRITER_TESTPAT_EN
  localparam logic [7:0] Blk16 = 8'hFF;
`else
  localparam logic [7:0] Blk16 = 8'h00;
`endif

  fb_pixel_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .x          (x),
    .y          (y),
    .draw_black (draw_black),
    .src_raddr  (src_raddr),
    .src_rdata  (src_rdata),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input logic [18:0] a);
    return a[7:0] ^ 8'hA0;
  endfunction

  // Synchronous replay memory: data one cycle after the address.
  always @(posedge clk) src_rdata <= pix(src_raddr);

  typedef struct {
    logic        iv;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        blk;
    logic        e_we;
    logic [18:0] e_addr;
    logic [7:0]  e_wdata;
    logic [18:0] e_raddr;
    logic        e_fd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [9:0] xx, input logic [8:0] yy,
                       input logic blk);
    in_valid   = iv;
    x          = xx;
    y          = yy;
    draw_black = blk;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 10'd0, 9'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst fb_we", {31'd0, fb_we}, 32'd0);
    chk("rst fb_addr", {13'd0, fb_addr}, 32'd0);
    chk("rst fb_wdata", {24'd0, fb_wdata}, 32'd0);
    chk("rst src_raddr", {13'd0, src_raddr}, 32'd0);
    chk("rst overflow", {31'd0, overflow}, 32'd0);
    chk("rst frame_done", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    fb_ready   = 1'b1;
    drive(1'b0, 10'd0, 9'd0, 1'b0);

    //          iv    x        y       blk   we    addr        wdata  raddr       fd
    vecs[0] = '{1'b1, 10'd5,   9'd2,   1'b0, 1'b0, 19'd0,      8'h00, 19'd0,      1'b0};
    vecs[1] = '{1'b1, 10'd16,  9'd0,   1'b1, 1'b0, 19'd0,      8'h00, 19'd1285,   1'b0};
    vecs[2] = '{1'b1, 10'd640, 9'd0,   1'b0, 1'b0, 19'd0,      8'h00, 19'd16,     1'b0};
    vecs[3] = '{1'b1, 10'd0,   9'd480, 1'b0, 1'b1, 19'd1285,   8'hA5, 19'd16,     1'b0};
    vecs[4] = '{1'b1, 10'd639, 9'd479, 1'b0, 1'b1, 19'd16,     Blk16, 19'd16,     1'b0};
    vecs[5] = '{1'b0, 10'd3,   9'd3,   1'b0, 1'b0, 19'd0,      8'h00, 19'd307199, 1'b0};
    vecs[6] = '{1'b0, 10'd3,   9'd3,   1'b0, 1'b0, 19'd0,      8'h00, 19'd307199, 1'b0};
    vecs[7] = '{1'b0, 10'd3,   9'd3,   1'b0, 1'b1, 19'd307199, 8'h5F, 19'd307199, 1'b0};
    vecs[8] = '{1'b0, 10'd3,   9'd3,   1'b0, 1'b0, 19'd0,      8'h00, 19'd307199, 1'b1};
    vecs[9] = '{1'b0, 10'd3,   9'd3,   1'b0, 1'b0, 19'd0,      8'h00, 19'd307199, 1'b0};

    do_reset();

    // Table: latency, address math, black, range discard, last address, frame_done.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d fb_we", i), {31'd0, fb_we}, {31'd0, vecs[i].e_we});
      chk($sformatf("vec%0d src_raddr", i), {13'd0, src_raddr}, {13'd0, vecs[i].e_raddr});
      chk($sformatf("vec%0d frame_done", i), {31'd0, frame_done}, {31'd0, vecs[i].e_fd});
      chk($sformatf("vec%0d overflow", i), {31'd0, overflow}, 32'd0);
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d fb_addr", i), {13'd0, fb_addr}, {13'd0, vecs[i].e_addr});
        chk($sformatf("vec%0d fb_wdata", i), {24'd0, fb_wdata}, {24'd0, vecs[i].e_wdata});
      end
      drive(vecs[i].iv, vecs[i].x, vecs[i].y, vecs[i].blk);
    end

    // Stall: 6 pixels into a stalled 4-deep FIFO; 2 dropped, head held.
    do_reset();
    fb_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        chk($sformatf("stall c%0d fb_we", c), {31'd0, fb_we}, 32'd1);
        chk($sformatf("stall c%0d fb_addr", c), {13'd0, fb_addr}, 32'd0);
        chk($sformatf("stall c%0d fb_wdata", c), {24'd0, fb_wdata}, {24'd0, pix(19'd0)});
      end
      if (c == 5) chk("stall pre-drop overflow", {31'd0, overflow}, 32'd0);
      if (c == 9) chk("stall overflow", {31'd0, overflow}, 32'd1);
      if (c < 6) drive(1'b1, 10'(c), 9'd0, 1'b0);
      else drive(1'b0, 10'd0, 9'd0, 1'b0);
    end
    fb_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d fb_we", k), {31'd0, fb_we}, 32'd1);
      chk($sformatf("drain%0d fb_addr", k), {13'd0, fb_addr}, k);
      chk($sformatf("drain%0d fb_wdata", k), {24'd0, fb_wdata}, {24'd0, pix(19'(k))});
    end
    @(negedge clk);
    chk("drain empty fb_we", {31'd0, fb_we}, 32'd0);
    chk("drain sticky overflow", {31'd0, overflow}, 32'd1);

    // Reset with 3 entries queued.
    fb_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 3) drive(1'b1, 10'(c + 8), 9'd1, 1'b0);
      else drive(1'b0, 10'd0, 9'd0, 1'b0);
    end
    @(negedge clk);
    chk("queued fb_we", {31'd0, fb_we}, 32'd1);
    chk("queued fb_addr", {13'd0, fb_addr}, 32'd648);
    chk("queued overflow", {31'd0, overflow}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst fb_we", {31'd0, fb_we}, 32'd0);
    chk("midrst overflow", {31'd0, overflow}, 32'd0);
    chk("midrst fb_addr", {13'd0, fb_addr}, 32'd0);
    chk("midrst src_raddr", {13'd0, src_raddr}, 32'd0);
    reset    = 1'b0;
    fb_ready = 1'b1;
    drive(1'b1, 10'd7, 9'd0, 1'b0);
    @(negedge clk);
    chk("postrst c1 fb_we", {31'd0, fb_we}, 32'd0);
    drive(1'b0, 10'd0, 9'd0, 1'b0);
    @(negedge clk);
    chk("postrst c2 fb_we", {31'd0, fb_we}, 32'd0);
    @(negedge clk);
    chk("postrst c3 fb_we", {31'd0, fb_we}, 32'd1);
    chk("postrst c3 fb_addr", {13'd0, fb_addr}, 32'd7);
    chk("postrst c3 fb_wdata", {24'd0, fb_wdata}, {24'd0, pix(19'd7)});

    // Full FIFO, then ready with continuous push: no drop, head lags by depth.
    do_reset();
    fb_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c >= 6 && c <= 25) begin
        chk($sformatf("full c%0d fb_we", c), {31'd0, fb_we}, 32'd1);
        chk($sformatf("full c%0d fb_addr", c), {13'd0, fb_addr}, c - 6);
        chk($sformatf("full c%0d fb_wdata", c), {24'd0, fb_wdata}, {24'd0, pix(19'(c - 6))});
      end
      if (c == 26) chk("full drained fb_we", {31'd0, fb_we}, 32'd0);
      if (c < 20) drive(1'b1, 10'(c), 9'd0, 1'b0);
      else drive(1'b0, 10'd0, 9'd0, 1'b0);
      if (c >= 6) fb_ready = 1'b1;
    end
    chk("full overflow", {31'd0, overflow}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
